reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor to the decode-stage register bank.
- Generalised data width, register count and number of read ports.
- Optional hard-wired zero register.
- Optional same-cycle write-to-read bypass.
- Per-register pending-write scoreboard that flags RAW hazards to the hazard unit.
- Sits in decode; writeback drives the write port, the issue logic drives the scoreboard.

Parameters:
- DATA_W, 32, bits per register.
- NUM_REGS, 32, register count; power of two, at least 2.
- NUM_READ, 2, number of independent read ports; 1 to 4.
- ZERO_REG, 1, when 1, register 0 always reads 0, ignores writes and is never pending.
- BYPASS, 1, when 1, a read of the register being written this cycle returns the write data.
- ADDR_W (localparam), $clog2(NUM_REGS).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_READ*ADDR_W  packed read addresses; port k uses slice [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_READ*DATA_W  packed read data; port k uses slice [k*DATA_W +: DATA_W].
- rd_pending  out  NUM_READ  bit k is 1 when the register addressed by port k has an outstanding write.
- wr_en  in  1  writeback write enable.
- wr_addr  in  ADDR_W  writeback destination register.
- wr_data  in  DATA_W  writeback value.
- iss_en  in  1  an instruction with a destination register issues this cycle.
- iss_addr  in  ADDR_W  destination of the issuing instruction.
- pending_cnt  out  ADDR_W+1  number of registers with a pending write.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - All registers clear to 0.
  - All pending bits clear.
  - pending_cnt = 0.
  - rd_pending = 0 for every port.
  - rd_data = 0 for every port (all registers are 0).
- Reset deasserted mid-burst: no write or issue presented while reset is high takes effect.
- Write:
  - On a rising edge with wr_en=1, reg[wr_addr] <= wr_data.
  - Write is suppressed when ZERO_REG=1 and wr_addr=0.
- Read: combinational, zero-latency, all ports independent.
  - rd_data[k] = reg[rd_addr[k]].
  - With ZERO_REG=1, address 0 reads 0.
  - With BYPASS=1, if wr_en=1 and wr_addr=rd_addr[k], rd_data[k] = wr_data. Zero-register reads stay 0.
  - With BYPASS=0, the old value is returned until the edge.
  - Two ports reading the same register both get the same value.
- Scoreboard: one pending bit per register.
  - Set on an edge with iss_en=1 at pend[iss_addr].
  - Cleared on an edge with wr_en=1 at pend[wr_addr].
  - Simultaneous iss_en and wr_en to the same address: pending stays 1, because the new producer wins.
  - Simultaneous operations to different addresses: both take effect.
  - Issue to an already-pending register: the bit stays 1, no counting of multiple producers. The hazard unit must stall the second issue; this is not checked here.
  - Writeback to a non-pending register: the bit stays 0 and the write still occurs.
  - With ZERO_REG=1, the register 0 bit is never set.
- rd_pending[k] = pend[rd_addr[k]], with these refinements:
  - When BYPASS=1 and a same-cycle write to that address clears it, rd_pending[k] = 0 in that cycle, unless iss_en also targets that address that cycle.
  - With ZERO_REG=1, address 0 always gives 0.
- pending_cnt: registered population count of the pending bits. It is updated on the same edge as the bits and equals the popcount of the pend vector after that edge.
- Range: it never exceeds NUM_REGS, or NUM_REGS-1 when ZERO_REG=1.
- Out-of-range addresses cannot occur because NUM_REGS is a power of two.

Decomposition:
- Shared package `regfile_pkg`:
  - Default DATA_W and NUM_REGS.
  - ADDR_W function.
  - Constant ZERO_REG_ID = 0.
- One sub-module: `sb_popcount`, a parametrised NUM_REGS-wide population counter feeding pending_cnt.
- Storage, bypass and read muxing are written inline with a generate loop over registers and read ports.

Test Plan:
1. Reset:
   - Assert reset mid-run with reg 5 = 0xDEADBEEF and pend[5]=1.
   - Required: reg 5 reads 0x0, rd_pending=0 and pending_cnt=0 immediately, before any clock edge.
2. Zero register:
   - wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF, then read addr 0 on both ports.
   - Required: rd_data=0x0 on both ports.
   - Also iss_addr=0: required pending_cnt stays 0.
3. Bypass:
   - Reg 7 = 0x11; same cycle drive wr_en=1, wr_addr=7, wr_data=0x22 with rd_addr[0]=7.
   - Required with BYPASS=1: rd_data[0]=0x22 in that cycle.
   - Required with BYPASS=0: rd_data[0]=0x11, then 0x22 after the edge.
4. Scoreboard lifecycle:
   - Issue to 3, then issue to 9 the next cycle.
   - Required: pending_cnt=1 then 2; rd_pending high when reading 3 and when reading 9.
   - Writeback to 3. Required: pending_cnt=1 and pend[3]=0 after the edge.
5. Simultaneous issue and writeback to 4, with pend[4]=1:
   - Required: pend[4] stays 1, pending_cnt is unchanged, and reg 4 holds the written value.
6. Multi-port (NUM_READ=4, DATA_W=16, NUM_REGS=16):
   - Write reg i = 0x100+i, then read addresses {1,1,15,0}.
   - Required: 0x101, 0x101, 0x10F, 0x000.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the decode-stage register file with scoreboard.
// Latency: n/a (package only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int ZERO_REG_ID  = 0;

    // Address width for a register count, never narrower than one bit.
    function automatic int addr_w(input int num_regs);
        return (num_regs <= 2) ? 1 : $clog2(num_regs);
    endfunction

endpackage

// File: rtl/sb_popcount.sv
// Population count of the pending-write vector.
// Latency: combinational.
// Backpressure: none.
module sb_popcount #(
    parameter int N     = 32,
    parameter int CNT_W = 6
) (
    input  logic [N-1:0]     bits,
    output logic [CNT_W-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + CNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with write bypass and a per-register pending-write scoreboard.
// Latency: reads combinational; writes, pending bits and pending_cnt update on the clock edge.
// Backpressure: none; the hazard unit stalls issue using rd_pending.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = addr_w(NUM_REGS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*DATA_W-1:0]   rd_data,
    output logic [NUM_READ-1:0]          rd_pending,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         iss_en,
    input  logic [ADDR_W-1:0]            iss_addr,
    output logic [ADDR_W:0]              pending_cnt
);

    logic [NUM_REGS-1:0][DATA_W-1:0] reg_q;
    logic [NUM_REGS-1:0]             pend;
    logic [NUM_REGS-1:0]             pend_nxt;
    logic [ADDR_W:0]                 cnt_nxt;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        if (ZERO_REG != 0 && r == ZERO_REG_ID) begin : g_zero
            assign reg_q[r]    = '0;
            assign pend[r]     = 1'b0;
            assign pend_nxt[r] = 1'b0;
        end else begin : g_live
            logic [DATA_W-1:0] q;
            logic              p;
            logic              wr_hit;
            logic              iss_hit;

            assign wr_hit  = wr_en  && (wr_addr  == ADDR_W'(r));
            assign iss_hit = iss_en && (iss_addr == ADDR_W'(r));
            // A new producer issuing on the writeback cycle keeps the bit set.
            assign pend_nxt[r] = iss_hit | (p & ~wr_hit);

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    q <= '0;
                    p <= 1'b0;
                end else begin
                    if (wr_hit) begin
                        q <= wr_data;
                    end
                    p <= pend_nxt[r];
                end
            end

            assign reg_q[r] = q;
            assign pend[r]  = p;
        end
    end

    sb_popcount #(
        .N     (NUM_REGS),
        .CNT_W (ADDR_W + 1)
    ) u_popcount (
        .bits (pend_nxt),
        .cnt  (cnt_nxt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_cnt <= '0;
        end else begin
            pending_cnt <= cnt_nxt;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              is_zero;
        logic              byp_hit;
        logic              iss_same;

        assign addr     = rd_addr[k*ADDR_W +: ADDR_W];
        assign is_zero  = (ZERO_REG != 0) && (addr == ADDR_W'(ZERO_REG_ID));
        assign byp_hit  = (BYPASS != 0) && wr_en && (wr_addr == addr);
        assign iss_same = iss_en && (iss_addr == addr);

        assign rd_data[k*DATA_W +: DATA_W] = is_zero ? '0 :
                                             byp_hit ? wr_data : reg_q[addr];
        assign rd_pending[k] = is_zero                ? 1'b0 :
                               (byp_hit && !iss_same) ? 1'b0 : pend[addr];
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed stimulus with a queued-expectation scoreboard.
// Instance a is the default build; instance b is 16x16, four ports, no bypass.
module tb_reg_file_sb;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_pending;
    logic        a_wr_en;
    logic [4:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic        a_iss_en;
    logic [4:0]  a_iss_addr;
    logic [5:0]  a_pending_cnt;

    logic [15:0] b_rd_addr;
    logic [63:0] b_rd_data;
    logic [3:0]  b_rd_pending;
    logic        b_wr_en;
    logic [3:0]  b_wr_addr;
    logic [15:0] b_wr_data;
    logic        b_iss_en;
    logic [3:0]  b_iss_addr;
    logic [4:0]  b_pending_cnt;

    reg_file_sb dut_a (
        .clock       (clk),
        .reset       (reset),
        .rd_addr     (a_rd_addr),
        .rd_data     (a_rd_data),
        .rd_pending  (a_rd_pending),
        .wr_en       (a_wr_en),
        .wr_addr     (a_wr_addr),
        .wr_data     (a_wr_data),
        .iss_en      (a_iss_en),
        .iss_addr    (a_iss_addr),
        .pending_cnt (a_pending_cnt)
    );

    reg_file_sb #(
        .DATA_W   (16),
        .NUM_REGS (16),
        .NUM_READ (4),
        .ZERO_REG (1),
        .BYPASS   (0)
    ) dut_b (
        .clock       (clk),
        .reset       (reset),
        .rd_addr     (b_rd_addr),
        .rd_data     (b_rd_data),
        .rd_pending  (b_rd_pending),
        .wr_en       (b_wr_en),
        .wr_addr     (b_wr_addr),
        .wr_data     (b_wr_data),
        .iss_en      (b_iss_en),
        .iss_addr    (b_iss_addr),
        .pending_cnt (b_pending_cnt)
    );

    string       name_q[$];
    int          sel_q[$];
    logic [63:0] exp_q[$];
    logic        chk_req = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            0:       return {32'h0, a_rd_data[31:0]};
            1:       return {32'h0, a_rd_data[63:32]};
            2:       return {62'h0, a_rd_pending};
            3:       return {58'h0, a_pending_cnt};
            4:       return {48'h0, b_rd_data[15:0]};
            5:       return {48'h0, b_rd_data[31:16]};
            6:       return {48'h0, b_rd_data[47:32]};
            7:       return {48'h0, b_rd_data[63:48]};
            8:       return {60'h0, b_rd_pending};
            9:       return {59'h0, b_pending_cnt};
            default: return 64'hX;
        endcase
    endfunction

    // Scoreboard monitor: drains queued expectations whenever a sample is requested.
    initial begin
        forever begin
            wait (chk_req == 1'b1);
            while (sel_q.size() > 0) begin
                string       n;
                int          s;
                logic [63:0] e;
                logic [63:0] act;
                n   = name_q.pop_front();
                s   = sel_q.pop_front();
                e   = exp_q.pop_front();
                act = observe(s);
                n_tests++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, e);
                end
            end
            chk_req = 1'b0;
        end
    end

    task automatic expect_v(input string n, input int sel, input logic [63:0] e);
        name_q.push_back(n);
        sel_q.push_back(sel);
        exp_q.push_back(e);
    endtask

    task automatic sample();
        #1;
        chk_req = 1'b1;
        fork
            wait (chk_req == 1'b0);
            #3;
        join_any
        disable fork;
        if (chk_req) begin
            n_tests++;
            n_fail++;
            $display("FAIL monitor_timeout: got pending request expected drained queue");
            chk_req = 1'b0;
        end
    endtask

    task automatic idle();
        a_wr_en  = 1'b0; a_wr_addr  = '0; a_wr_data = '0;
        a_iss_en = 1'b0; a_iss_addr = '0;
        b_wr_en  = 1'b0; b_wr_addr  = '0; b_wr_data = '0;
        b_iss_en = 1'b0; b_iss_addr = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle();
        a_rd_addr = '0;
        b_rd_addr = '0;
        repeat (2) @(negedge clk);

        // Reset state
        a_rd_addr = {5'd5, 5'd5};
        expect_v("rst_a_data0", 0, 64'h0);
        expect_v("rst_a_pend",  2, 64'h0);
        expect_v("rst_a_cnt",   3, 64'h0);
        expect_v("rst_b_cnt",   9, 64'h0);
        sample();
        @(negedge clk);
        reset = 1'b0;

        // Populate reg 5 and mark it pending, then reset asynchronously mid-cycle
        @(negedge clk);
        a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF;
        a_iss_en = 1'b1; a_iss_addr = 5'd5;
        @(negedge clk);
        idle();
        expect_v("pre_rst_data", 0, 64'hDEADBEEF);
        expect_v("pre_rst_pend", 2, 64'h3);
        expect_v("pre_rst_cnt",  3, 64'h1);
        sample();
        reset = 1'b1;
        expect_v("async_rst_data0", 0, 64'h0);
        expect_v("async_rst_data1", 1, 64'h0);
        expect_v("async_rst_pend",  2, 64'h0);
        expect_v("async_rst_cnt",   3, 64'h0);
        sample();

        // Traffic presented while reset is high must be ignored
        a_wr_en = 1'b1; a_wr_addr = 5'd6; a_wr_data = 32'h55;
        a_iss_en = 1'b1; a_iss_addr = 5'd6;
        @(negedge clk);
        idle();
        reset = 1'b0;
        a_rd_addr = {5'd6, 5'd6};
        expect_v("rst_held_data", 0, 64'h0);
        expect_v("rst_held_pend", 2, 64'h0);
        expect_v("rst_held_cnt",  3, 64'h0);
        sample();

        // Zero register: writes and issues ignored, bypass does not leak
        @(negedge clk);
        a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'hFFFFFFFF;
        a_iss_en = 1'b1; a_iss_addr = 5'd0;
        a_rd_addr = {5'd0, 5'd0};
        expect_v("zero_byp_data0", 0, 64'h0);
        expect_v("zero_byp_data1", 1, 64'h0);
        expect_v("zero_byp_pend",  2, 64'h0);
        sample();
        @(negedge clk);
        idle();
        expect_v("zero_data0", 0, 64'h0);
        expect_v("zero_data1", 1, 64'h0);
        expect_v("zero_cnt",   3, 64'h0);
        sample();

        // Bypass enabled: same-cycle write visible on both ports
        @(negedge clk);
        a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h11;
        @(negedge clk);
        a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h22;
        a_rd_addr = {5'd7, 5'd7};
        expect_v("byp_data0", 0, 64'h22);
        expect_v("byp_data1", 1, 64'h22);
        sample();
        @(negedge clk);
        idle();
        expect_v("byp_after", 0, 64'h22);
        expect_v("nonpend_wr_cnt", 3, 64'h0);
        sample();

        // Bypass disabled: old value until the edge
        @(negedge clk);
        b_wr_en = 1'b1; b_wr_addr = 4'd7; b_wr_data = 16'h11;
        @(negedge clk);
        b_wr_en = 1'b1; b_wr_addr = 4'd7; b_wr_data = 16'h22;
        b_rd_addr = {4'd0, 4'd0, 4'd0, 4'd7};
        expect_v("nobyp_old", 4, 64'h11);
        sample();
        @(negedge clk);
        idle();
        expect_v("nobyp_new", 4, 64'h22);
        sample();

        // Scoreboard lifecycle on 3 and 9
        @(negedge clk);
        a_iss_en = 1'b1; a_iss_addr = 5'd3;
        a_rd_addr = {5'd9, 5'd3};
        expect_v("sb_pre_pend", 2, 64'h0);
        expect_v("sb_pre_cnt",  3, 64'h0);
        sample();
        @(negedge clk);
        a_iss_en = 1'b1; a_iss_addr = 5'd9;
        expect_v("sb_iss3_cnt",  3, 64'h1);
        expect_v("sb_iss3_pend", 2, 64'h1);
        sample();
        @(negedge clk);
        idle();
        expect_v("sb_iss9_cnt",  3, 64'h2);
        expect_v("sb_iss9_pend", 2, 64'h3);
        sample();
        @(negedge clk);
        a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'h33;
        expect_v("sb_wb3_byp_pend", 2, 64'h2);
        expect_v("sb_wb3_cnt_hold", 3, 64'h2);
        sample();
        @(negedge clk);
        idle();
        expect_v("sb_wb3_cnt",  3, 64'h1);
        expect_v("sb_wb3_pend", 2, 64'h2);
        expect_v("sb_wb3_data", 0, 64'h33);
        sample();

        // Simultaneous issue and writeback to pending reg 4
        @(negedge clk);
        a_iss_en = 1'b1; a_iss_addr = 5'd4;
        @(negedge clk);
        idle();
        expect_v("sim_pre_cnt", 3, 64'h2);
        sample();
        @(negedge clk);
        a_wr_en = 1'b1; a_wr_addr = 5'd4; a_wr_data = 32'h44;
        a_iss_en = 1'b1; a_iss_addr = 5'd4;
        a_rd_addr = {5'd9, 5'd4};
        expect_v("sim_same_pend", 2, 64'h3);
        expect_v("sim_same_byp",  0, 64'h44);
        sample();
        @(negedge clk);
        idle();
        expect_v("sim_cnt",  3, 64'h2);
        expect_v("sim_pend", 2, 64'h3);
        expect_v("sim_data", 0, 64'h44);
        sample();

        // Issue 10 and writeback 9 in the same cycle
        @(negedge clk);
        a_iss_en = 1'b1; a_iss_addr = 5'd10;
        a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h99;
        a_rd_addr = {5'd9, 5'd10};
        @(negedge clk);
        idle();
        expect_v("diff_cnt",   3, 64'h2);
        expect_v("diff_pend",  2, 64'h1);
        expect_v("diff_data9", 1, 64'h99);
        sample();

        // Multi-port instance: fill, then read {1,1,15,0}
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            b_wr_en = 1'b1; b_wr_addr = 4'(i); b_wr_data = 16'h100 + 16'(i);
        end
        @(negedge clk);
        idle();
        b_iss_en = 1'b1; b_iss_addr = 4'd0;
        b_rd_addr = {4'd0, 4'd15, 4'd1, 4'd1};
        expect_v("mp_port0", 4, 64'h101);
        expect_v("mp_port1", 5, 64'h101);
        expect_v("mp_port2", 6, 64'h10F);
        expect_v("mp_port3", 7, 64'h000);
        sample();
        @(negedge clk);
        idle();
        expect_v("mp_zero_iss_cnt",  9, 64'h0);
        expect_v("mp_zero_iss_pend", 8, 64'h0);
        sample();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
